// File: rtl/op_dispatch.sv
// op_dispatch: reads the formula of a [subject formula] reduction cell and hands opcode 4 to the
// increment block. Define OP_DISPATCH_CELL_OP_EN to also execute opcode 3 (cell test) locally.
module op_dispatch #(
  parameter int unsigned ADDR_W   = 28,
  parameter int unsigned DATA_W   = 64,
  parameter logic [27:0] NIL      = 28'h0,
  parameter logic [2:0]  MUX_EXEC = 3'd2,
  parameter logic [2:0]  MUX_INCR = 3'd4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        op_start,
  input  logic [ADDR_W-1:0] op_address,
  input  logic [DATA_W-1:0] op_data,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] read_data1,
  output logic              mem_execute,
  output logic [ADDR_W-1:0] address1,
  output logic [1:0]        mem_func,
  output logic [DATA_W-1:0] write_data,
  output logic [2:0]        incr_start,
  output logic [ADDR_W-1:0] incr_address,
  output logic [DATA_W-1:0] incr_data,
  input  logic              incr_finished,
  input  logic [7:0]        incr_error,
  output logic [7:0]        dispatch_error,
  output logic [3:0]        return_sys_func,
  output logic [3:0]        return_state,
  output logic              finished
);

  typedef struct packed {
    logic [5:0]  pad;
    logic        hed_tag;
    logic        tel_tag;
    logic [27:0] hed;
    logic [27:0] tel;
  } word_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_READ_FORM,
    S_DISPATCH,
    S_WAIT_INCR,
`ifdef OP_DISPATCH_CELL_OP_EN
    S_CELL_WRITE,
    S_CELL_WAIT,
`endif
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [1:0]  FUNC_IDLE     = 2'b00;
  localparam logic [1:0]  FUNC_GET      = 2'b01;
`ifdef OP_DISPATCH_CELL_OP_EN
  localparam logic [1:0]  FUNC_SET      = 2'b10;
`endif
  localparam logic [27:0] OPC_CELL      = 28'd3;
  localparam logic [27:0] OPC_INCR      = 28'd4;
  localparam logic [7:0]  ERR_OP_ATOM   = 8'h01;
  localparam logic [7:0]  ERR_FORM_CELL = 8'h02;
  localparam logic [7:0]  ERR_OPCODE    = 8'h03;
  localparam logic [7:0]  ERR_INCR      = 8'h04;
  localparam logic [3:0]  SYS_FUNC_READ = 4'h1;
  localparam logic [3:0]  SYS_READ_INIT = 4'h0;

  state_e              state_q, state_d;
  logic                sel_prev_q, sel_prev_d;
  logic                mem_execute_q, mem_execute_d;
  logic [ADDR_W-1:0]   address1_q, address1_d;
  logic [1:0]          mem_func_q, mem_func_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic [2:0]          incr_start_q, incr_start_d;
  logic [ADDR_W-1:0]   incr_address_q, incr_address_d;
  logic [DATA_W-1:0]   incr_data_q, incr_data_d;
  logic [7:0]          dispatch_error_q, dispatch_error_d;
  logic [3:0]          return_sys_func_q, return_sys_func_d;
  logic [3:0]          return_state_q, return_state_d;
  logic                finished_q, finished_d;
  logic [ADDR_W-1:0]   res_addr_q, res_addr_d;
  word_t               formula_q, formula_d;

  word_t op_word;
  word_t rd_word;
  logic  start_sel;
  logic  start_edge;
  logic  unused_op_bits;

  assign op_word        = op_data;
  assign rd_word        = read_data1;
  assign start_sel      = (op_start == MUX_EXEC);
  assign start_edge     = start_sel && !sel_prev_q;
  assign unused_op_bits = ^{op_word.pad, op_word.hed_tag, op_word.hed};

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through the case can infer a latch.
    state_d           = state_q;
    sel_prev_d        = start_sel;
    mem_execute_d     = mem_execute_q;
    address1_d        = address1_q;
    mem_func_d        = mem_func_q;
    write_data_d      = write_data_q;
    incr_start_d      = incr_start_q;
    incr_address_d    = incr_address_q;
    incr_data_d       = incr_data_q;
    dispatch_error_d  = dispatch_error_q;
    return_sys_func_d = return_sys_func_q;
    return_state_d    = return_state_q;
    finished_d        = finished_q;
    res_addr_d        = res_addr_q;
    formula_d         = formula_q;

    if (start_edge) begin
      // A fresh start edge restarts from a clean slate, even out of ERROR.
      state_d           = S_INIT;
      mem_execute_d     = 1'b0;
      address1_d        = '0;
      mem_func_d        = FUNC_IDLE;
      write_data_d      = '0;
      incr_start_d      = '0;
      incr_address_d    = '0;
      incr_data_d       = '0;
      dispatch_error_d  = '0;
      return_sys_func_d = '0;
      return_state_d    = '0;
      finished_d        = 1'b0;
      res_addr_d        = '0;
      formula_d         = '0;
    end else if (!start_sel) begin
      mem_execute_d = 1'b0;
      incr_start_d  = '0;
      finished_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: finished_d = 1'b0;
        S_INIT: begin
          if (op_word.tel_tag) begin
            dispatch_error_d = ERR_OP_ATOM;
            state_d          = S_ERROR;
          end else begin
            address1_d    = ADDR_W'(op_word.tel);
            mem_func_d    = FUNC_GET;
            mem_execute_d = 1'b1;
            res_addr_d    = op_address;
            state_d       = S_READ_FORM;
          end
        end
        S_READ_FORM: begin
          mem_execute_d = 1'b0;
          mem_func_d    = FUNC_IDLE;
          if (mem_ready) begin
            formula_d = rd_word;
            if (!rd_word.hed_tag) begin
              dispatch_error_d = ERR_FORM_CELL;
              state_d          = S_ERROR;
            end else begin
              state_d = S_DISPATCH;
            end
          end
        end
        S_DISPATCH: begin
          if (formula_q.hed == OPC_INCR) begin
            incr_address_d = res_addr_q;
            incr_data_d    = formula_q;
            incr_start_d   = MUX_INCR;
            state_d        = S_WAIT_INCR;
`ifdef OP_DISPATCH_CELL_OP_EN
          end else if (formula_q.hed == OPC_CELL) begin
            state_d = S_CELL_WRITE;
`endif
          end else begin
            dispatch_error_d = ERR_OPCODE;
            state_d          = S_ERROR;
          end
        end
        S_WAIT_INCR: begin
          incr_start_d = MUX_INCR;
          // An error reported alongside the done pulse takes precedence.
          if (incr_error != 8'h00) begin
            dispatch_error_d = ERR_INCR;
            incr_start_d     = '0;
            state_d          = S_ERROR;
          end else if (incr_finished) begin
            incr_start_d      = '0;
            finished_d        = 1'b1;
            return_sys_func_d = SYS_FUNC_READ;
            return_state_d    = SYS_READ_INIT;
            state_d           = S_DONE;
          end
        end
`ifdef OP_DISPATCH_CELL_OP_EN
        S_CELL_WRITE: begin
          address1_d    = res_addr_q;
          write_data_d  = DATA_W'({6'b0, 1'b1, 1'b1,
                                   (formula_q.tel_tag ? 28'h1 : 28'h0), NIL});
          mem_func_d    = FUNC_SET;
          mem_execute_d = 1'b1;
          state_d       = S_CELL_WAIT;
        end
        S_CELL_WAIT: begin
          mem_execute_d = 1'b0;
          mem_func_d    = FUNC_IDLE;
          if (mem_ready) begin
            finished_d        = 1'b1;
            return_sys_func_d = SYS_FUNC_READ;
            return_state_d    = SYS_READ_INIT;
            state_d           = S_DONE;
          end
        end
`endif
        S_DONE: begin
          finished_d = 1'b0;
          state_d    = S_IDLE;
        end
        S_ERROR: begin
          mem_execute_d = 1'b0;
          mem_func_d    = FUNC_IDLE;
          incr_start_d  = '0;
          finished_d    = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= S_IDLE;
      sel_prev_q        <= 1'b0;
      mem_execute_q     <= 1'b0;
      address1_q        <= '0;
      mem_func_q        <= FUNC_IDLE;
      write_data_q      <= '0;
      incr_start_q      <= '0;
      incr_address_q    <= '0;
      incr_data_q       <= '0;
      dispatch_error_q  <= '0;
      return_sys_func_q <= '0;
      return_state_q    <= '0;
      finished_q        <= 1'b0;
      res_addr_q        <= '0;
      formula_q         <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge value of the others.
      state_q           <= state_d;
      sel_prev_q        <= sel_prev_d;
      mem_execute_q     <= mem_execute_d;
      address1_q        <= address1_d;
      mem_func_q        <= mem_func_d;
      write_data_q      <= write_data_d;
      incr_start_q      <= incr_start_d;
      incr_address_q    <= incr_address_d;
      incr_data_q       <= incr_data_d;
      dispatch_error_q  <= dispatch_error_d;
      return_sys_func_q <= return_sys_func_d;
      return_state_q    <= return_state_d;
      finished_q        <= finished_d;
      res_addr_q        <= res_addr_d;
      formula_q         <= formula_d;
    end
  end

  assign mem_execute     = mem_execute_q;
  assign address1        = address1_q;
  assign mem_func        = mem_func_q;
  assign write_data      = write_data_q;
  assign incr_start      = incr_start_q;
  assign incr_address    = incr_address_q;
  assign incr_data       = incr_data_q;
  assign dispatch_error  = dispatch_error_q;
  assign return_sys_func = return_sys_func_q;
  assign return_state    = return_state_q;
  assign finished        = finished_q;

endmodule

// File: tb/tb_op_dispatch.sv
// tb_op_dispatch: directed and randomized checks of op_dispatch against a rule-level model,
// with a small memory / increment-block responder built into run_op.
`timescale 1ns/1ps
module tb_op_dispatch;
  localparam int          ADDR_W   = 28;
  localparam int          DATA_W   = 64;
  localparam logic [2:0]  MUX_EXEC = 3'd2;
  localparam logic [2:0]  MUX_INCR = 3'd4;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        op_start;
  logic [ADDR_W-1:0] op_address;
  logic [DATA_W-1:0] op_data;
  logic              mem_ready;
  logic [DATA_W-1:0] read_data1;
  logic              mem_execute;
  logic [ADDR_W-1:0] address1;
  logic [1:0]        mem_func;
  logic [DATA_W-1:0] write_data;
  logic [2:0]        incr_start;
  logic [ADDR_W-1:0] incr_address;
  logic [DATA_W-1:0] incr_data;
  logic              incr_finished;
  logic [7:0]        incr_error;
  logic [7:0]        dispatch_error;
  logic [3:0]        return_sys_func;
  logic [3:0]        return_state;
  logic              finished;

  always #5 clk = ~clk;

  op_dispatch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NIL(28'h0),
                .MUX_EXEC(MUX_EXEC), .MUX_INCR(MUX_INCR)) dut (
    .clk(clk), .rst(rst), .op_start(op_start), .op_address(op_address), .op_data(op_data),
    .mem_ready(mem_ready), .read_data1(read_data1), .mem_execute(mem_execute),
    .address1(address1), .mem_func(mem_func), .write_data(write_data),
    .incr_start(incr_start), .incr_address(incr_address), .incr_data(incr_data),
    .incr_finished(incr_finished), .incr_error(incr_error), .dispatch_error(dispatch_error),
    .return_sys_func(return_sys_func), .return_state(return_state), .finished(finished)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_word(input logic ht, input logic tt,
                                          input logic [27:0] hed, input logic [27:0] tel);
    return {6'b0, ht, tt, hed, tel};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"}, {mem_execute, mem_func, incr_start, finished}, 0);
    check({tag, "_address1"}, address1, 0);
    check({tag, "_write_data"}, write_data, 0);
    check({tag, "_incr_addr"}, incr_address, 0);
    check({tag, "_incr_data"}, incr_data, 0);
    check({tag, "_err_ret"}, {dispatch_error, return_sys_func, return_state}, 0);
  endtask

  // Observations gathered by run_op.
  int          n_exec, incr_first, incr_cnt, fin_count, fin_cyc, pulse_cyc, ready_cyc;
  logic [1:0]  ex_func [2];
  logic [27:0] ex_addr [2];
  logic [63:0] ex_data [2];
  bit          incr_seen, incr_unstable, timed_out;
  logic [27:0] incr_addr_o;
  logic [63:0] incr_data_o;
  logic [3:0]  ret_func, ret_state;
  logic [7:0]  err_at_start, end_err;
  logic        end_strobes;

  task automatic run_op(input string tag, input logic [27:0] addr, input logic [63:0] opd,
                        input logic [63:0] form, input int mem_lat, input int incr_lat,
                        input bit fin, input logic [7:0] ierr, input bit abort);
    int ready_at = -1;
    int tail     = -1;
    n_exec = 0; incr_cnt = 0; fin_count = 0; incr_seen = 0; incr_unstable = 0;
    incr_first = -1; fin_cyc = -1; pulse_cyc = -1; ready_cyc = -1; timed_out = 1;
    ret_func = '0; ret_state = '0;
    for (int k = 0; k < 2; k++) begin ex_func[k] = 'x; ex_addr[k] = 'x; ex_data[k] = 'x; end
    op_start = 3'd0; mem_ready = 1'b0; incr_finished = 1'b0; incr_error = 8'h00;
    @(posedge clk); #1;
    op_start = MUX_EXEC; op_address = addr; op_data = opd;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(posedge clk); #1;
      mem_ready = 1'b0; incr_finished = 1'b0; incr_error = 8'h00;
      if (cyc == 0) err_at_start = dispatch_error;
      if (mem_execute) begin
        if (n_exec < 2) begin
          ex_func[n_exec] = mem_func; ex_addr[n_exec] = address1; ex_data[n_exec] = write_data;
        end
        n_exec++;
        ready_at = cyc + mem_lat;
      end
      if (cyc == ready_at) begin
        mem_ready = 1'b1; read_data1 = form; ready_cyc = cyc;
      end
      if (incr_start == MUX_INCR) begin
        if (!incr_seen) begin
          incr_seen = 1; incr_first = cyc; incr_addr_o = incr_address; incr_data_o = incr_data;
        end else if (incr_address !== incr_addr_o || incr_data !== incr_data_o) begin
          incr_unstable = 1;
        end
        incr_cnt++;
        if (abort) begin
          #2 rst = 1'b0;
          #1 check_all_zero({tag, "_async_rst"});
          timed_out = 0;
          break;
        end
        if (incr_cnt == incr_lat) begin
          pulse_cyc = cyc; incr_finished = fin; incr_error = ierr;
        end
      end
      if (finished) begin
        fin_count++;
        if (fin_count == 1) begin
          fin_cyc = cyc; ret_func = return_sys_func; ret_state = return_state;
        end
      end
      if (tail < 0 && (finished || dispatch_error != 8'h00)) tail = cyc + 3;
      if (cyc == tail) begin
        timed_out = 0;
        break;
      end
    end
    end_err     = dispatch_error;
    end_strobes = mem_execute | (incr_start != 3'd0) | finished;
    mem_ready = 1'b0; incr_finished = 1'b0; incr_error = 8'h00; op_start = 3'd0;
  endtask

  // Reference model: expected outcome from the dispatch rules alone.
  task automatic check_op(input string tag, input logic [27:0] addr, input logic [63:0] opd,
                          input logic [63:0] form, input int mem_lat, input logic [7:0] ierr);
    logic [7:0] exp_err;
    bit incr_path, cell_path, cell_en;
    logic [27:0] opcode;
`ifdef OP_DISPATCH_CELL_OP_EN
    cell_en = 1;
`else
    cell_en = 0;
`endif
    opcode = form[55:28];
    incr_path = !opd[56] && form[57] && opcode == 28'd4;
    cell_path = !opd[56] && form[57] && opcode == 28'd3 && cell_en;
    if (opd[56])                exp_err = 8'h01;
    else if (!form[57])         exp_err = 8'h02;
    else if (incr_path)         exp_err = (ierr != 8'h00) ? 8'h04 : 8'h00;
    else if (cell_path)         exp_err = 8'h00;
    else                        exp_err = 8'h03;

    check({tag, "_timeout"}, timed_out, 0);
    check({tag, "_err_cleared"}, err_at_start, 0);
    check({tag, "_err"}, end_err, exp_err);
    check({tag, "_n_exec"}, n_exec, opd[56] ? 0 : (cell_path ? 2 : 1));
    check({tag, "_idle_strobes"}, end_strobes, 0);
    check({tag, "_fin_count"}, fin_count, exp_err == 8'h00);
    if (!opd[56]) check({tag, "_get"}, {ex_func[0], ex_addr[0]}, {2'b01, opd[27:0]});
    check({tag, "_incr_seen"}, incr_seen, incr_path);
    if (incr_path) begin
      check({tag, "_incr_latency"}, incr_first, 3 + mem_lat);
      check({tag, "_incr_addr"}, incr_addr_o, addr);
      check({tag, "_incr_data"}, incr_data_o, form);
      check({tag, "_incr_stable"}, incr_unstable, 0);
    end
    if (cell_path)
      check({tag, "_set"}, {ex_func[1], ex_addr[1], ex_data[1]},
            {2'b10, addr, mk_word(1'b1, 1'b1, form[56] ? 28'h1 : 28'h0, 28'h0)});
    if (exp_err == 8'h00) begin
      check({tag, "_fin_lag"}, fin_cyc, (incr_path ? pulse_cyc : ready_cyc) + 1);
      check({tag, "_ret"}, {ret_func, ret_state}, {4'h1, 4'h0});
    end
  endtask

  initial begin
    logic [27:0] a, h;
    logic [63:0] od, fm;
    logic [7:0]  ie;
    int          sel, ml, il;
    bit          fi;

    rst = 1'b0; op_start = 3'd0; op_address = '0; op_data = '0; mem_ready = 1'b0;
    read_data1 = '0; incr_finished = 1'b0; incr_error = 8'h00;
    #12 check_all_zero("reset");
    @(negedge clk); rst = 1'b1;

    // Operand cell whose tail is an atom.
    od = mk_word(1'b0, 1'b1, 28'h0, 28'h10);
    run_op("op_atom", 28'h20, od, '0, 1, 1, 1, 8'h00, 0);
    check_op("op_atom", 28'h20, od, '0, 1, 8'h00);

    // Increment dispatch, memory answering 2 cycles after the request.
    od = mk_word(1'b0, 1'b0, 28'h0, 28'h10);
    fm = mk_word(1'b1, 1'b1, 28'd4, 28'd7);
    run_op("incr_ok", 28'h44, od, fm, 2, 2, 1, 8'h00, 0);
    check_op("incr_ok", 28'h44, od, fm, 2, 8'h00);
    check("incr_ok_operand", incr_data_o[27:0], 28'd7);

    fm = mk_word(1'b1, 1'b1, 28'd9, 28'd1);
    run_op("opc_9", 28'h45, od, fm, 1, 1, 1, 8'h00, 0);
    check_op("opc_9", 28'h45, od, fm, 1, 8'h00);

    fm = mk_word(1'b0, 1'b1, 28'd4, 28'd1);
    run_op("form_cell", 28'h46, od, fm, 3, 1, 1, 8'h00, 0);
    check_op("form_cell", 28'h46, od, fm, 3, 8'h00);

    fm = mk_word(1'b1, 1'b1, 28'd4, 28'd2);
    run_op("incr_err_fin", 28'h47, od, fm, 1, 3, 1, 8'h05, 0);
    check_op("incr_err_fin", 28'h47, od, fm, 1, 8'h05);

    fm = mk_word(1'b1, 1'b0, 28'd3, 28'h33);
    run_op("opc_3", 28'h48, od, fm, 2, 1, 1, 8'h00, 0);
    check_op("opc_3", 28'h48, od, fm, 2, 8'h00);

    // Asynchronous reset while waiting on the increment block, then a clean rerun.
    fm = mk_word(1'b1, 1'b1, 28'd4, 28'd9);
    run_op("abort", 28'h49, od, fm, 1, 5, 1, 8'h00, 1);
    check("abort_timeout", timed_out, 0);
    @(negedge clk); rst = 1'b1;
    run_op("after_abort", 28'h4a, od, fm, 1, 1, 1, 8'h00, 0);
    check_op("after_abort", 28'h4a, od, fm, 1, 8'h00);

    for (int t = 0; t < 40; t++) begin
      a   = 28'($urandom);
      sel = $urandom_range(0, 9);
      h   = (sel == 2) ? 28'd3 : (sel == 3) ? 28'($urandom_range(0, 12)) : 28'd4;
      od  = mk_word(1'($urandom), sel == 0, 28'($urandom), 28'($urandom));
      fm  = mk_word(sel != 1, 1'($urandom), h, 28'($urandom));
      ml  = $urandom_range(1, 3);
      il  = $urandom_range(1, 3);
      ie  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      fi  = (ie == 8'h00) ? 1'b1 : 1'($urandom);
      run_op("rand", a, od, fm, ml, il, fi, ie, 0);
      check_op("rand", a, od, fm, ml, ie);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/op_dispatch.md
# op_dispatch

Execute-stage dispatcher that sits directly upstream of the increment block. It takes a reduction cell `[subject formula]` from memory traversal, reads the formula cell, and decodes the opcode atom. Opcode 4 is handed to the increment block over its start/finished handshake; other opcodes are rejected with an error code. When the downstream operation completes, it returns control to traversal with a one-cycle `finished` pulse.

## Interface
Parameters:
- `ADDR_W`, 28: memory address width.
- `DATA_W`, 64: memory word width. The word is `{6'b0, hed_tag[57], tel_tag[56], hed[55:28], tel[27:0]}`; tag 1 = atom, 0 = cell.
- `NIL`, 28'h0: tel value marking "no tail".
- `MUX_EXEC`, 3'd2: select code that starts this block.
- `MUX_INCR`, 3'd4: select code driven to the increment block.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Asynchronous, active-low.
- `op_start`, in, 3: mux select from traversal. The block starts on a rising match to `MUX_EXEC`.
- `op_address`, in, ADDR_W: address of the reduction cell; this is also the result write address.
- `op_data`, in, DATA_W: contents of the reduction cell.
- `mem_ready`, in, 1: memory operation complete.
- `read_data1`, in, DATA_W: read result.
- `mem_execute`, out, 1: memory request strobe.
- `address1`, out, ADDR_W: memory address.
- `mem_func`, out, 2: memory function. 2'b01 = GET_CONTENTS, 2'b10 = SET_CONTENTS, 0 = idle.
- `write_data`, out, DATA_W: write word.
- `incr_start`, out, 3: select to the increment block; `MUX_INCR` or 0.
- `incr_address`, out, ADDR_W: result address for the increment block.
- `incr_data`, out, DATA_W: formula word; its tel field is the operand.
- `incr_finished`, in, 1: one-cycle done pulse from the increment block.
- `incr_error`, in, 8: nonzero means the increment block failed.
- `dispatch_error`, out, 8: error code, sticky.
- `return_sys_func`, out, 4: next traversal function. Value `SYS_FUNC_READ` = 4'h1.
- `return_state`, out, 4: next traversal state. Value `SYS_READ_INIT` = 4'h0.
- `finished`, out, 1: one-cycle completion pulse.

## Operation
- States: IDLE, INIT, READ_FORM, DISPATCH, WAIT_INCR, CELL_WRITE, CELL_WAIT, DONE, ERROR.
- **Reset and restart.** Reset, or a rising edge of `op_start==MUX_EXEC` (compared against a registered previous value), forces IDLE→INIT. All outputs are cleared to 0, including `dispatch_error`.
- **Inactive select.** While `op_start != MUX_EXEC`, the state is frozen and `incr_start` is driven 0.
- **INIT.**
  - If `op_data` tel_tag is atom: `dispatch_error = 8'h01`, go to ERROR.
  - Otherwise: `address1 = op_data.tel`, `mem_func = GET_CONTENTS`, `mem_execute = 1`, go to READ_FORM.
- **READ_FORM.**
  - Cycles without `mem_ready`: drive `mem_execute` and `mem_func` to 0.
  - On `mem_ready`: latch `read_data1` as the formula.
  - If the formula's hed_tag is cell: error 8'h02.
  - Otherwise go to DISPATCH.
- **DISPATCH** (decodes the opcode from formula hed):
  - Opcode 4: `incr_address = op_address`, `incr_data = formula`, `incr_start = MUX_INCR`, go to WAIT_INCR.
  - Opcode 3: go to CELL_WRITE if CELL_OP_EN is defined; otherwise error 8'h03.
  - Any other opcode: error 8'h03.
- **WAIT_INCR.** `incr_start` stays at `MUX_INCR`.
  - If `incr_error != 0`: error 8'h04, `incr_start = 0`.
  - Else on `incr_finished`: `incr_start = 0`, go to DONE.
  - If both occur in the same cycle, the error wins.
- **DONE.**
  - Set `return_sys_func = 4'h1` and `return_state = 4'h0`.
  - Pulse `finished` for 1 cycle, then go to IDLE.
  - IDLE clears `finished` and waits for the next start edge.
- **ERROR.** Terminal until reset or a new start edge. All strobes are held at 0 and `finished` is never asserted.

## Timing
- Memory handshake:
  - `mem_execute` is high for exactly the issuing cycle.
  - `address1` and `write_data` are stable until `mem_ready` is seen.
  - `mem_ready` is sampled only in the wait states.
- Latency from the start edge to `incr_start` asserted is 3 + N_read cycles, where N_read is the number of cycles until `mem_ready`.
- `finished` asserts 1 cycle after `incr_finished`.
- `incr_data` and `incr_address` are stable for the whole time `incr_start == MUX_INCR`.
- Reset mid-operation aborts immediately. Any outstanding memory request is abandoned; memory recovers through its own reset.

## Configuration
- Macro: `OP_DISPATCH_CELL_OP_EN`.
- **Defined:** opcode 3 is executed locally.
  - CELL_WRITE writes `{6'b0, 1, 1, v, NIL}` to `op_address`, with `mem_func = SET_CONTENTS`.
  - `v = 28'h0` if the formula tel_tag is cell, `28'h1` if atom.
  - CELL_WAIT waits for `mem_ready`, then goes to DONE.
- **Undefined:** opcode 3 produces error 8'h03, and the CELL states are absent.

## Test plan
- Start edge with `op_data` tel_tag atom → `dispatch_error = 8'h01`, no `mem_execute`, `finished` stays 0.
- `op_data.tel = 28'h10`, memory returns `{hed = 4 atom, tel = 7 atom}` after 2 cycles:
  - Required: `address1 = 28'h10`, GET_CONTENTS.
  - Required: `incr_start = MUX_INCR`, `incr_address = op_address`, `incr_data.tel = 7`.
  - Then an `incr_finished` pulse → `finished` for 1 cycle, `return_sys_func = 4'h1`.
- Formula hed = 9 → error 8'h03. Formula hed is a cell → error 8'h02.
- `incr_error = 8'h05` and `incr_finished` in the same cycle → error 8'h04, `finished` stays 0.
- `rst` low during WAIT_INCR → all outputs 0 asynchronously. A fresh start edge then runs cleanly.
- With `OP_DISPATCH_CELL_OP_EN` defined, opcode 3 with a cell tel → SET_CONTENTS of `{6'b0, 1, 1, 28'h0, NIL}` to `op_address`, then `finished`.
